// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - sequencer/arbiter feeding the bit-serial symmetric FIR core
// Serializes coefficient words, issues start pulses and holds one result with backpressure.
module fir_seq_ctrl #(
  parameter int BITS = 8,
  parameter int TAPS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            c_valid,
  output logic            c_ready,
  input  logic [BITS-1:0] c_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data,
  output logic            busy,
  output logic            fir_start,
  output logic [BITS-1:0] fir_x,
  output logic            fir_coeff_load,
  output logic            fir_coeff_bit,
  input  logic [BITS-1:0] fir_y
);

  localparam int N   = (TAPS / 2) * BITS;
  localparam int BCW = $clog2(BITS);
  localparam int LCW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, CLOAD, START, BUSY, DONE} state_t;

  state_t          state;
  logic [BITS-1:0] shreg;
  logic [BCW-1:0]  bit_cnt;
  logic [LCW-1:0]  lat_cnt;
  logic            capture;

  // Coefficient channel wins any tie with the sample channel.
  assign c_ready       = (state == IDLE);
  assign s_ready       = (state == IDLE) && !c_valid;
  assign busy          = (state != IDLE);
  assign fir_coeff_bit = shreg[BITS-1];
  assign capture       = (state == DONE) && (!m_valid || m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      lat_cnt        <= '0;
      fir_start      <= 1'b0;
      fir_x          <= '0;
      fir_coeff_load <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= '0;
    end else begin
      fir_start <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (c_valid) begin
            shreg          <= c_data;
            bit_cnt        <= '0;
            fir_coeff_load <= 1'b1;
            state          <= CLOAD;
          end else if (s_valid) begin
            fir_x     <= s_data;
            fir_start <= 1'b1;
            state     <= START;
          end
        end
        CLOAD: begin
          // The word is fully shifted out on the last cycle, so the bit reads 0 afterwards.
          shreg <= {shreg[BITS-2:0], 1'b0};
          if (bit_cnt == BCW'(BITS - 1)) begin
            fir_coeff_load <= 1'b0;
            state          <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        START: begin
          lat_cnt <= LCW'(N);
          state   <= BUSY;
        end
        BUSY: begin
          lat_cnt <= lat_cnt - LCW'(1);
          if (lat_cnt == LCW'(1)) state <= DONE;
        end
        DONE: begin
          // Reload overrides the drain clear above, giving back-to-back valid.
          if (capture) begin
            m_data  <= fir_y;
            m_valid <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed and randomized checks for fir_seq_ctrl
module tb_fir_seq_ctrl;
  localparam int BITS = 8;
  localparam int TAPS = 4;
  localparam int N    = (TAPS / 2) * BITS;
  localparam int LAT  = N + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            c_valid = 1'b0, c_ready;
  logic [BITS-1:0] c_data = '0;
  logic            s_valid = 1'b0, s_ready;
  logic [BITS-1:0] s_data = '0;
  logic            m_valid, m_ready = 1'b0;
  logic [BITS-1:0] m_data;
  logic            busy, fir_start, fir_coeff_load, fir_coeff_bit;
  logic [BITS-1:0] fir_x;
  logic [BITS-1:0] fir_y = '0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  fir_seq_ctrl #(.BITS(BITS), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .fir_start(fir_start), .fir_x(fir_x),
    .fir_coeff_load(fir_coeff_load), .fir_coeff_bit(fir_coeff_bit),
    .fir_y(fir_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample through an idle controller with an empty output register and m_ready low.
  task automatic do_sample(input logic [BITS-1:0] sd, input logic [BITS-1:0] y,
                           input bit drain, input string tag);
    int early;
    early = 0;
    s_valid = 1'b1; s_data = sd; fir_y = y;
    #1;
    check({tag, "_s_ready"}, s_ready, 1);
    tick();
    s_valid = 1'b0;
    #1;
    check({tag, "_start"}, fir_start, 1);
    check({tag, "_fir_x"}, fir_x, sd);
    for (int i = 2; i < LAT; i++) begin
      tick();
      if (m_valid || fir_start || fir_coeff_load) early++;
    end
    check({tag, "_quiet"}, early, 0);
    tick();
    check({tag, "_m_valid_at_lat"}, m_valid, 1);
    check({tag, "_m_data"}, m_data, y);
    check({tag, "_idle_after"}, busy, 0);
    if (drain) begin
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      #1;
      check({tag, "_drained"}, m_valid, 0);
    end
  endtask

  initial begin
    logic [BITS-1:0] word;
    logic [BITS-1:0] r;
    logic [BITS-1:0] last_s;
    logic [BITS-1:0] out_q[$];
    logic            bit_q[$];
    logic            c_acc, s_acc;
    int              wait_cnt;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_outs", {m_valid, fir_start, fir_coeff_load, fir_coeff_bit}, 0);
    check("rst_data", {m_data, fir_x}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_c_ready", c_ready, 1);
    check("idle_s_ready", s_ready, 1);
    check("idle_busy", busy, 0);

    // Coefficient 0xA5 shifted out MSB first over exactly BITS cycles
    word = 8'hA5;
    c_valid = 1'b1; c_data = word;
    #1;
    check("c_accept_ready", c_ready, 1);
    tick();
    c_valid = 1'b0;
    #1;
    for (int k = 0; k < BITS; k++) begin
      check("cload_load", fir_coeff_load, 1);
      check("cload_bit", fir_coeff_bit, word[BITS-1-k]);
      check("cload_readies", {c_ready, s_ready}, 0);
      tick();
    end
    #1;
    check("cload_end_load", fir_coeff_load, 0);
    check("cload_end_readies", {c_ready, s_ready}, 2'b11);

    // Single sample, latency N+3
    do_sample(8'h03, 8'h42, 1'b1, "smp1");

    // Both channels offered: coefficient first, sample in the following IDLE cycle
    c_valid = 1'b1; c_data = 8'h3C; s_valid = 1'b1; s_data = 8'h09; fir_y = 8'h77;
    #1;
    check("both_c_ready", c_ready, 1);
    check("both_s_ready", s_ready, 0);
    tick();
    c_valid = 1'b0;
    #1;
    wait_cnt = 0;
    for (int k = 0; k < BITS; k++) begin
      if (!fir_coeff_load || fir_start || s_ready) wait_cnt++;
      tick();
    end
    #1;
    check("both_cload_clean", wait_cnt, 0);
    s_valid = 1'b0;
    do_sample(8'h09, 8'h77, 1'b1, "both_smp");

    // Backpressure: second result waits in DONE until the first is drained
    do_sample(8'h10, 8'h11, 1'b0, "bp1");
    s_valid = 1'b1; s_data = 8'h20; fir_y = 8'h22;
    #1;
    check("bp2_s_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    repeat (LAT + 6) tick();
    check("bp_hold_busy", busy, 1);
    check("bp_hold_valid", m_valid, 1);
    check("bp_hold_data", m_data, 8'h11);
    check("bp_hold_s_ready", s_ready, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    check("bp_swap_valid", m_valid, 1);
    check("bp_swap_data", m_data, 8'h22);
    check("bp_swap_idle", busy, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    check("bp_final_drain", m_valid, 0);

    // Asynchronous reset in the middle of BUSY
    s_valid = 1'b1; s_data = 8'h55; fir_y = 8'h66;
    #1;
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_outs", {m_valid, fir_start, fir_coeff_load, fir_coeff_bit}, 0);
    check("arst_data", {m_data, fir_x}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    do_sample(8'h07, 8'h5A, 1'b1, "post_rst");

    // Randomized traffic against a queue-based reference
    c_acc = 1'b0; s_acc = 1'b0; last_s = '0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      tick();
      if (c_acc) c_valid = 1'b0;
      if (s_acc) s_valid = 1'b0;
      if (cyc < 2000) begin
        if (!c_valid && $urandom_range(0, 7) == 0) begin c_valid = 1'b1; c_data = BITS'($urandom); end
        if (!s_valid && $urandom_range(0, 2) == 0) begin s_valid = 1'b1; s_data = BITS'($urandom); end
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      #1;
      check("rnd_no_overlap", fir_start & fir_coeff_load, 0);
      check("rnd_ready_busy", {c_ready & busy, s_ready & busy}, 0);
      check("rnd_priority", s_ready & c_valid, 0);
      if (fir_start) check("rnd_fir_x", fir_x, last_s);
      if (fir_coeff_load) begin
        if (bit_q.size() == 0) check("rnd_coeff_extra", 1, 0);
        else check("rnd_coeff_bit", fir_coeff_bit, bit_q.pop_front());
      end
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) check("rnd_out_extra", 1, 0);
        else begin
          r = out_q.pop_front();
          check("rnd_m_data", m_data, r);
        end
      end
      c_acc = c_valid && c_ready;
      s_acc = s_valid && s_ready;
      if (c_acc) for (int k = BITS - 1; k >= 0; k--) bit_q.push_back(c_data[k]);
      if (s_acc) begin
        r = BITS'($urandom);
        out_q.push_back(r);
        fir_y = r;
        last_s = s_data;
      end
    end
    tick();
    check("rnd_out_empty", out_q.size(), 0);
    check("rnd_bits_empty", bit_q.size(), 0);
    check("rnd_final_idle", {busy, m_valid}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer and arbiter in front of the bit-serial symmetric FIR core. It accepts coefficient words and input samples on independent valid/ready channels and serializes coefficient words onto the core's 1-bit coefficient port. It issues single-cycle start pulses, waits out the fixed compute latency, and captures the core's result into a one-deep output register with valid/ready backpressure. It guarantees that the core never sees a coefficient shift during computation and never sees a start while in coefficient-load.

## Interface
- BITS, 8: sample/coefficient/result width; must match the core.
- TAPS, 4: core tap count (even, ≥2); N = (TAPS/2)*BITS compute cycles.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- c_valid  in  1  coefficient word offered.
- c_ready  out  1  coefficient word accepted when c_valid & c_ready.
- c_data  in  BITS  coefficient word.
- s_valid  in  1  sample offered.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- s_data  in  BITS  sample.
- m_valid  out  1  result available.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_data  out  BITS  result.
- busy  out  1  high in any state other than IDLE.
- fir_start  out  1  one-cycle start pulse to the core.
- fir_x  out  BITS  sample to the core, registered.
- fir_coeff_load  out  1  core coefficient shift enable.
- fir_coeff_bit  out  1  core coefficient serial bit, MSB first.
- fir_y  in  BITS  core accumulator output.

## Operation
- States: IDLE, CLOAD, START, BUSY, DONE.
- IDLE:
  - c_ready = 1 always.
  - s_ready = !c_valid, so the coefficient channel has strict priority.
  - Coefficient accept: load c_data into the shift register, clear the bit counter, go to CLOAD.
  - Sample accept: fir_x <= s_data, go to START.
- CLOAD (exactly BITS cycles):
  - fir_coeff_load = 1 and fir_coeff_bit = shreg[BITS-1]; shift left each cycle.
  - After the BITS-th cycle, return to IDLE.
  - The mandatory IDLE cycle keeps coeff_load low for at least one cycle before any start, so the core leaves its load state.
- START (1 cycle): fir_start = 1 with fir_x stable; load the latency counter with N; go to BUSY.
- BUSY (exactly N cycles): decrement the counter; go to DONE when it expires.
- DONE:
  - Capture fir_y into m_data and set m_valid if the output register is empty, or is being drained this cycle (m_valid & m_ready).
  - Then go to IDLE.
  - Otherwise stay in DONE. fir_y stays stable because no new start is issued.
- Output register: m_valid clears on m_valid & m_ready unless it is reloaded in the same cycle.
- fir_start and fir_coeff_load are never high in the same cycle. c_ready and s_ready are low outside IDLE.
- Counters: bit counter is $clog2(BITS) wide; latency counter is $clog2(N+1) wide; no wrap.

## Timing
- Reset (async assert, sync release): state IDLE; m_valid, m_data, fir_x, fir_start, fir_coeff_load, fir_coeff_bit, busy all 0; shift register and counters 0.
- The core shares rst_n. Reset mid-operation aborts everything with no partial output.
- Let the sample accept happen in cycle A:
  - START is cycle A+1.
  - BUSY spans A+2..A+N+1.
  - DONE is A+N+2.
  - m_valid is first high in A+N+3, i.e. latency N+3.
- Coefficient accept in cycle C: fir_coeff_load is high C+1..C+BITS; IDLE (ready again) at C+BITS+1.
- Maximum sample throughput with no backpressure: one per N+3 cycles.
- Simultaneous m_ready and capture in DONE: the new result replaces the old one with no gap in m_valid.

## Test plan
- Reset, then release with all inputs 0: every output is 0; c_ready = s_ready = 1 in the first IDLE cycle; busy = 0.
- c_data = 0xA5 accepted: fir_coeff_load high for exactly 8 cycles with fir_coeff_bit = 1,0,1,0,0,1,0,1; c_ready and s_ready low throughout, then 1.
- s_data = 0x03 accepted with fir_y driven to 0x42 by the core model:
  - fir_start high for one cycle with fir_x = 0x03.
  - m_valid rises exactly 19 cycles after the accept (BITS=8, TAPS=4); m_data = 0x42.
- c_valid and s_valid both high in IDLE: coefficient accepted first (8 load cycles); sample accepted in the following IDLE cycle; fir_start never overlaps fir_coeff_load.
- Backpressure, with m_ready = 0 and two samples whose results are 0x11 then 0x22:
  - The controller holds in DONE; m_data = 0x11 is kept.
  - After a one-cycle m_ready pulse, m_data = 0x22 the next cycle; no loss and order preserved.
- rst_n asserted in the middle of BUSY: all outputs 0 immediately (asynchronous); after release, a new sample completes with normal N+3 latency.
